// File: rtl/model_lstm_state_update_pkg.sv
// Shared LSTM controller definitions: fixed-point defaults, ONE/ZERO constants and the FSM state encoding.
package model_lstm_state_update_pkg;

  localparam int LSTM_DATA_SIZE     = 64;
  localparam int LSTM_CONTROL_SIZE  = 64;
  localparam int LSTM_FRACTION_SIZE = 32;

  localparam logic [LSTM_DATA_SIZE-1:0] LSTM_ZERO = '0;
  localparam logic [LSTM_DATA_SIZE-1:0] LSTM_ONE  = LSTM_DATA_SIZE'(1) << LSTM_FRACTION_SIZE;

  typedef enum logic [2:0] {
    STARTER_STATE    = 3'd0,
    INPUT_STATE      = 3'd1,
    MULTIPLY_STATE   = 3'd2,
    ACCUMULATE_STATE = 3'd3,
    OUTPUT_STATE     = 3'd4
  } lstm_state_e;

endpackage

// File: rtl/model_lstm_state_update_if.sv
// Command/gate-stream/result bundle between the gate stage, the state update and the output stage.
interface model_lstm_state_update_if
  import model_lstm_state_update_pkg::*;
#(
  parameter int DATA_SIZE    = LSTM_DATA_SIZE,
  parameter int CONTROL_SIZE = LSTM_CONTROL_SIZE
);
  logic                    START;
  logic                    CLEAR;
  logic                    READY;
  logic                    DATA_ENABLE;
  logic                    DATA_IN_ENABLE;
  logic [DATA_SIZE-1:0]    F_IN;
  logic [DATA_SIZE-1:0]    I_IN;
  logic [DATA_SIZE-1:0]    A_IN;
  logic [DATA_SIZE-1:0]    S_OUT;
  logic                    DATA_OUT_ENABLE;
  logic [CONTROL_SIZE-1:0] INDEX_OUT;

  modport master (
    output START, CLEAR, DATA_IN_ENABLE, F_IN, I_IN, A_IN,
    input  READY, DATA_ENABLE, S_OUT, DATA_OUT_ENABLE, INDEX_OUT
  );

  modport slave (
    input  START, CLEAR, DATA_IN_ENABLE, F_IN, I_IN, A_IN,
    output READY, DATA_ENABLE, S_OUT, DATA_OUT_ENABLE, INDEX_OUT
  );
endinterface

// File: rtl/model_lstm_fixed_multiplier.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRACTION_SIZE, reduce to DATA_SIZE.
// Clamps on overflow when LSTM_STATE_SATURATION_EN is defined, otherwise wraps.
module model_lstm_fixed_multiplier
  import model_lstm_state_update_pkg::*;
#(
  parameter int DATA_SIZE     = LSTM_DATA_SIZE,
  parameter int FRACTION_SIZE = LSTM_FRACTION_SIZE
) (
  input  logic signed [DATA_SIZE-1:0] a,
  input  logic signed [DATA_SIZE-1:0] b,
  output logic signed [DATA_SIZE-1:0] product
);
  localparam int FULL = 2 * DATA_SIZE;

  logic signed [FULL-1:0] full_product;
  logic signed [FULL-1:0] shifted;

  always_comb begin
    full_product = $signed({{DATA_SIZE{a[DATA_SIZE-1]}}, a}) *
                   $signed({{DATA_SIZE{b[DATA_SIZE-1]}}, b});
    shifted      = full_product >>> FRACTION_SIZE;
    // NOTE: product gets a value before any conditional override, so no latch can be inferred.
    product      = shifted[DATA_SIZE-1:0];
`ifdef LSTM_STATE_SATURATION_EN
    // Any disagreement among the bits above the kept sign bit means the value left the range.
    if (shifted[FULL-1:DATA_SIZE-1] != {(DATA_SIZE+1){shifted[FULL-1]}})
      product = shifted[FULL-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                : {1'b0, {(DATA_SIZE-1){1'b1}}};
`endif
  end

`ifndef LSTM_STATE_SATURATION_EN
  logic unused_high_bits;
  assign unused_high_bits = ^shifted[FULL-1:DATA_SIZE];
`endif

endmodule

// File: rtl/model_lstm_state_update.sv
// LSTM cell-state update: s(t)[l] = f[l]*s(t-1)[l] + i[l]*a[l], one element per 4 cycles.
// Optional overflow clamping of products and sum under LSTM_STATE_SATURATION_EN.
module model_lstm_state_update
  import model_lstm_state_update_pkg::*;
#(
  parameter int DATA_SIZE     = LSTM_DATA_SIZE,
  parameter int CONTROL_SIZE  = LSTM_CONTROL_SIZE,
  parameter int FRACTION_SIZE = LSTM_FRACTION_SIZE,
  parameter int SIZE_L_IN     = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  model_lstm_state_update_if.slave    bus
);
  localparam logic [2:0] S_STARTER    = STARTER_STATE;
  localparam logic [2:0] S_INPUT      = INPUT_STATE;
  localparam logic [2:0] S_MULTIPLY   = MULTIPLY_STATE;
  localparam logic [2:0] S_ACCUMULATE = ACCUMULATE_STATE;
  localparam logic [2:0] S_OUTPUT     = OUTPUT_STATE;

  localparam int ADDR_W = (SIZE_L_IN > 1) ? $clog2(SIZE_L_IN) : 1;
  localparam logic [CONTROL_SIZE-1:0] LAST_INDEX = CONTROL_SIZE'(SIZE_L_IN - 1);

  logic [2:0]                  state;
  logic [CONTROL_SIZE-1:0]     index;
  logic [ADDR_W-1:0]           addr;
  logic signed [DATA_SIZE-1:0] f_reg, i_reg, a_reg;
  logic signed [DATA_SIZE-1:0] p0_reg, p1_reg, p0_next, p1_next;
  logic signed [DATA_SIZE-1:0] sum_reg, sum_next;
  logic signed [DATA_SIZE:0]   sum_wide;
  logic signed [DATA_SIZE-1:0] s_mem [SIZE_L_IN];

  assign addr            = index[ADDR_W-1:0];
  assign bus.DATA_ENABLE = (state == S_INPUT);

  model_lstm_fixed_multiplier #(.DATA_SIZE(DATA_SIZE), .FRACTION_SIZE(FRACTION_SIZE)) u_mul_fs (
    .a(f_reg), .b(s_mem[addr]), .product(p0_next)
  );

  model_lstm_fixed_multiplier #(.DATA_SIZE(DATA_SIZE), .FRACTION_SIZE(FRACTION_SIZE)) u_mul_ia (
    .a(i_reg), .b(a_reg), .product(p1_next)
  );

  // One guard bit catches the sum overflow.
  always_comb begin
    sum_wide = {p0_reg[DATA_SIZE-1], p0_reg} + {p1_reg[DATA_SIZE-1], p1_reg};
    sum_next = sum_wide[DATA_SIZE-1:0];
`ifdef LSTM_STATE_SATURATION_EN
    if (sum_wide[DATA_SIZE] != sum_wide[DATA_SIZE-1])
      sum_next = sum_wide[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                     : {1'b0, {(DATA_SIZE-1){1'b1}}};
`endif
  end

`ifndef LSTM_STATE_SATURATION_EN
  logic unused_sum_carry;
  assign unused_sum_carry = sum_wide[DATA_SIZE];
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state               <= S_STARTER;
      index               <= '0;
      f_reg               <= '0;
      i_reg               <= '0;
      a_reg               <= '0;
      p0_reg              <= '0;
      p1_reg              <= '0;
      sum_reg             <= '0;
      bus.READY           <= 1'b0;
      bus.DATA_OUT_ENABLE <= 1'b0;
      bus.S_OUT           <= '0;
      bus.INDEX_OUT       <= '0;
      // NOTE: the state memory is small and must read as zero after reset, so it is reset like a register file.
      for (int k = 0; k < SIZE_L_IN; k++) s_mem[k] <= '0;
    end else begin
      bus.READY           <= 1'b0;
      bus.DATA_OUT_ENABLE <= 1'b0;
      case (state)
        S_STARTER: begin
          if (bus.CLEAR)
            for (int k = 0; k < SIZE_L_IN; k++) s_mem[k] <= '0;
          if (bus.START) begin
            index <= '0;
            state <= S_INPUT;
          end
        end
        S_INPUT: begin
          if (bus.DATA_IN_ENABLE) begin
            f_reg <= bus.F_IN;
            i_reg <= bus.I_IN;
            a_reg <= bus.A_IN;
            state <= S_MULTIPLY;
          end
        end
        S_MULTIPLY: begin
          p0_reg <= p0_next;
          p1_reg <= p1_next;
          state  <= S_ACCUMULATE;
        end
        S_ACCUMULATE: begin
          sum_reg     <= sum_next;
          s_mem[addr] <= sum_next;
          state       <= S_OUTPUT;
        end
        S_OUTPUT: begin
          bus.S_OUT           <= sum_reg;
          bus.INDEX_OUT       <= index;
          bus.DATA_OUT_ENABLE <= 1'b1;
          if (index == LAST_INDEX) begin
            bus.READY <= 1'b1;
            state     <= S_STARTER;
          end else begin
            index <= index + 1'b1;
            state <= S_INPUT;
          end
        end
        default: state <= S_STARTER;
      endcase
    end
  end

endmodule

// File: tb/tb_model_lstm_state_update.sv
// Self-checking bench for model_lstm_state_update; expected values follow LSTM_STATE_SATURATION_EN if defined.
module tb_model_lstm_state_update;
  import model_lstm_state_update_pkg::*;

  localparam int W = 64;
  localparam int F = 32;
  localparam int L = 4;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  model_lstm_state_update_if #(.DATA_SIZE(W), .CONTROL_SIZE(64)) bus_if ();

  model_lstm_state_update #(
    .DATA_SIZE(W), .CONTROL_SIZE(64), .FRACTION_SIZE(F), .SIZE_L_IN(L)
  ) dut (
    .CLK(clk), .RST(rst_n), .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] ref_s [L];
  logic [W-1:0] last_s = '0;
  logic [W-1:0] fv [L];
  logic [W-1:0] iv [L];
  logic [W-1:0] av [L];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on exact 128-bit integers.
  function automatic logic [W-1:0] fx_reduce(input logic signed [2*W-1:0] v);
`ifdef LSTM_STATE_SATURATION_EN
    logic signed [2*W-1:0] hi, lo;
    hi = 128'($signed(MAX_POS));
    lo = -hi - 1;
    if (v > hi) return MAX_POS;
    if (v < lo) return ~MAX_POS;
`endif
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] fx_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] xs, ys, p;
    xs = 128'($signed(x));
    ys = 128'($signed(y));
    p  = xs * ys;
    p  = p >>> F;
    return fx_reduce(p);
  endfunction

  function automatic logic [W-1:0] small_rand();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {{28{r[35]}}, r[35:0]};
  endfunction

  task automatic start_vec(input bit clr);
    @(negedge clk);
    check("ready_one_cycle", 64'(bus_if.READY), 64'd0);
    bus_if.START = 1'b1;
    bus_if.CLEAR = clr;
    @(negedge clk);
    bus_if.START = 1'b0;
    bus_if.CLEAR = 1'b0;
    if (clr) for (int k = 0; k < L; k++) ref_s[k] = '0;
    check("start_data_enable", 64'(bus_if.DATA_ENABLE), 64'd1);
  endtask

  task automatic feed(input int l, input logic [W-1:0] f, input logic [W-1:0] i,
                      input logic [W-1:0] a, input int stall, input bit use_fixed,
                      input logic [W-1:0] fixed);
    logic [W-1:0] exp;
    int guard;
    for (int c = 0; c < stall; c++) begin
      bus_if.START = (c == 3);
      bus_if.CLEAR = (c == 5);
      @(negedge clk);
      check("stall_data_enable", 64'(bus_if.DATA_ENABLE), 64'd1);
      check("stall_no_output", 64'(bus_if.DATA_OUT_ENABLE), 64'd0);
      check("stall_hold_s_out", bus_if.S_OUT, last_s);
    end
    bus_if.START = 1'b0;
    bus_if.CLEAR = 1'b0;
    guard = 0;
    while (!bus_if.DATA_ENABLE && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("wait_data_enable", 64'(bus_if.DATA_ENABLE), 64'd1);

    exp = fx_reduce(128'($signed(fx_mul(f, ref_s[l]))) + 128'($signed(fx_mul(i, a))));
    ref_s[l] = exp;

    bus_if.F_IN = f;
    bus_if.I_IN = i;
    bus_if.A_IN = a;
    bus_if.DATA_IN_ENABLE = 1'b1;
    @(negedge clk);
    // Junk held valid while busy must be ignored.
    bus_if.F_IN = {$urandom, $urandom};
    bus_if.I_IN = {$urandom, $urandom};
    bus_if.A_IN = {$urandom, $urandom};
    check("accept_data_enable_low", 64'(bus_if.DATA_ENABLE), 64'd0);
    for (int c = 0; c < 3; c++) begin
      check("latency_no_output", 64'(bus_if.DATA_OUT_ENABLE), 64'd0);
      @(negedge clk);
    end
    bus_if.DATA_IN_ENABLE = 1'b0;
    check("out_enable", 64'(bus_if.DATA_OUT_ENABLE), 64'd1);
    check("s_out_model", bus_if.S_OUT, exp);
    if (use_fixed) check("s_out_fixed", bus_if.S_OUT, fixed);
    check("index_out", bus_if.INDEX_OUT, 64'(l));
    check("ready", 64'(bus_if.READY), 64'(l == L - 1));
    check("data_enable_after_out", 64'(bus_if.DATA_ENABLE), 64'(l != L - 1));
    last_s = exp;
  endtask

  task automatic run_vec(input bit clr, input int stall_elem, input bit use_fixed,
                         input logic [W-1:0] fixed);
    start_vec(clr);
    for (int l = 0; l < L; l++)
      feed(l, fv[l], iv[l], av[l], (l == stall_elem) ? 10 : 0, use_fixed, fixed);
  endtask

  initial begin
    bus_if.START = 1'b0;
    bus_if.CLEAR = 1'b0;
    bus_if.DATA_IN_ENABLE = 1'b0;
    bus_if.F_IN = '0;
    bus_if.I_IN = '0;
    bus_if.A_IN = '0;
    for (int k = 0; k < L; k++) ref_s[k] = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus_if.READY), 64'd0);
    check("rst_data_enable", 64'(bus_if.DATA_ENABLE), 64'd0);
    check("rst_out_enable", 64'(bus_if.DATA_OUT_ENABLE), 64'd0);
    check("rst_s_out", bus_if.S_OUT, 64'd0);
    check("rst_index_out", bus_if.INDEX_OUT, 64'd0);
    rst_n = 1'b1;

    // 0.5*0 + 1.0*0.25 = 0.25, then 0.5*0.25 + 0.25 = 0.375.
    for (int k = 0; k < L; k++) begin
      fv[k] = 64'h8000_0000; iv[k] = LSTM_ONE; av[k] = 64'h4000_0000;
    end
    run_vec(1'b0, -1, 1'b1, 64'h4000_0000);
    run_vec(1'b0, -1, 1'b1, 64'h6000_0000);

    // CLEAR with START: forget=1, input=0 leaves the cleared zero state.
    for (int k = 0; k < L; k++) begin
      fv[k] = LSTM_ONE; iv[k] = LSTM_ZERO; av[k] = {$urandom, $urandom};
    end
    run_vec(1'b1, -1, 1'b1, 64'd0);

    // Random in-range values, one vector with a mid-vector stall.
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < L; k++) begin
        fv[k] = small_rand(); iv[k] = small_rand(); av[k] = small_rand();
      end
      run_vec(1'b0, (v == 1) ? 1 : -1, 1'b0, '0);
    end

    // Full-width random operands exercise overflow handling.
    for (int k = 0; k < L; k++) begin
      fv[k] = {$urandom, $urandom}; iv[k] = {$urandom, $urandom}; av[k] = {$urandom, $urandom};
    end
    run_vec(1'b0, -1, 1'b0, '0);

    // Preset s to the maximum, then drive all gates at maximum.
    for (int k = 0; k < L; k++) begin
      fv[k] = LSTM_ZERO; iv[k] = LSTM_ONE; av[k] = MAX_POS;
    end
    run_vec(1'b1, -1, 1'b1, MAX_POS);
    for (int k = 0; k < L; k++) begin
      fv[k] = MAX_POS; iv[k] = MAX_POS; av[k] = MAX_POS;
    end
`ifdef LSTM_STATE_SATURATION_EN
    run_vec(1'b0, -1, 1'b1, MAX_POS);
`else
    run_vec(1'b0, -1, 1'b0, '0);
`endif

    // Reset while element 2 is in ACCUMULATE.
    for (int k = 0; k < L; k++) begin
      fv[k] = small_rand(); iv[k] = LSTM_ONE; av[k] = small_rand() | 64'h1;
    end
    start_vec(1'b0);
    feed(0, fv[0], iv[0], av[0], 0, 1'b0, '0);
    feed(1, fv[1], iv[1], av[1], 0, 1'b0, '0);
    bus_if.F_IN = fv[2];
    bus_if.I_IN = iv[2];
    bus_if.A_IN = av[2];
    bus_if.DATA_IN_ENABLE = 1'b1;
    @(negedge clk);
    bus_if.DATA_IN_ENABLE = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(bus_if.READY), 64'd0);
    check("midrst_data_enable", 64'(bus_if.DATA_ENABLE), 64'd0);
    check("midrst_out_enable", 64'(bus_if.DATA_OUT_ENABLE), 64'd0);
    check("midrst_s_out", bus_if.S_OUT, 64'd0);
    check("midrst_index_out", bus_if.INDEX_OUT, 64'd0);
    for (int k = 0; k < L; k++) ref_s[k] = '0;
    last_s = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < L; k++) begin
      fv[k] = LSTM_ONE; iv[k] = LSTM_ZERO; av[k] = {$urandom, $urandom};
    end
    run_vec(1'b0, -1, 1'b1, 64'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
